// File: rtl/cpu_sram_arbiter.sv
// cpu_sram_arbiter
//
// Shares one SRAM-like memory port between the instruction-fetch master and
// the data master. All three sides use the req/addr_ok/data_ok protocol.
// Each accepted request pushes the granted master ID into an in-order FIFO.
// Every mem_data_ok pops the head ID, which routes the response back to the
// master that issued the request.
//
// Optional build macro:
//   CPU_SRAM_ARB_RR_EN - when both masters request and no request is stalled,
//                        grant the master that was not granted last. Without
//                        it, data has fixed priority over inst.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   inst_req/addr               instruction master request (read only)
//   inst_addr_ok/data_ok/rdata  instruction master handshake and response
//   data_req/wr/size/addr/wdata data master request
//   data_addr_ok/data_ok/rdata  data master handshake and response
//   mem_req/wr/size/addr/wdata  request to the memory/AXI bridge
//   mem_addr_ok/data_ok/rdata   memory handshake and response
//   resp_err                    sticky: a response arrived with nothing outstanding
//
// Request lock:
//   lock | meaning
//   0    | free: the grant follows priority (or round robin)
//   1    | a request was presented but not accepted; lock_id is held until accepted

module cpu_sram_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ID_W            = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        resp_err
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [ID_W-1:0]  ID_INST  = '0;
    localparam logic [ID_W-1:0]  ID_DATA  = ID_W'(1);

    logic [ID_W-1:0]  id_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             lock;
    logic [ID_W-1:0]  lock_id;

    logic             fifo_full;
    logic             fifo_empty;
    logic             grant_valid;
    logic [ID_W-1:0]  grant_id;
    logic             grant_inst;
    logic             grant_data;
    logic             push;
    logic             pop;
    logic [ID_W-1:0]  head_id;

`ifdef CPU_SRAM_ARB_RR_EN
    logic [ID_W-1:0]  rr_last;
`endif

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);

    // The full check uses the registered count, so a slot freed by a pop
    // this cycle is only offered to the masters on the next cycle.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = ID_INST;
        if (!fifo_full) begin
            if (lock) begin
                grant_valid = 1'b1;
                grant_id    = lock_id;
            end else if (data_req && inst_req) begin
                grant_valid = 1'b1;
`ifdef CPU_SRAM_ARB_RR_EN
                grant_id    = (rr_last == ID_DATA) ? ID_INST : ID_DATA;
`else
                grant_id    = ID_DATA;
`endif
            end else if (data_req) begin
                grant_valid = 1'b1;
                grant_id    = ID_DATA;
            end else if (inst_req) begin
                grant_valid = 1'b1;
                grant_id    = ID_INST;
            end
        end
    end

    assign grant_inst = grant_valid && (grant_id == ID_INST);
    assign grant_data = grant_valid && (grant_id == ID_DATA);

    // Gating with reset keeps the bridge and both masters quiet while reset is held.
    assign mem_req   = !reset && ((grant_data && data_req) || (grant_inst && inst_req));
    assign mem_wr    = grant_data ? data_wr    : 1'b0;
    assign mem_size  = grant_data ? data_size  : 2'd2;
    assign mem_addr  = grant_data ? data_addr  : inst_addr;
    assign mem_wdata = grant_data ? data_wdata : 32'd0;

    assign push         = mem_req && mem_addr_ok;
    assign inst_addr_ok = push && grant_inst;
    assign data_addr_ok = push && grant_data;

    assign head_id      = id_fifo[rd_ptr];
    assign pop          = !reset && mem_data_ok && !fifo_empty;
    assign inst_data_ok = pop && (head_id == ID_INST);
    assign data_data_ok = pop && (head_id == ID_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    // ID storage holds no control state, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            id_fifo[wr_ptr] <= grant_id;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            lock     <= 1'b0;
            lock_id  <= ID_INST;
            resp_err <= 1'b0;
        end else begin
            // Power-of-two depth: the pointers wrap by plain overflow.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase

            if (push) begin
                lock <= 1'b0;
            end else if (mem_req) begin
                lock    <= 1'b1;
                lock_id <= grant_id;
            end

            if (mem_data_ok && fifo_empty) begin
                resp_err <= 1'b1;
            end
        end
    end

`ifdef CPU_SRAM_ARB_RR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last <= ID_INST;
        end else if (push) begin
            rr_last <= grant_id;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
module tb_cpu_sram_arbiter;

    localparam int MAX = 4;
`ifdef CPU_SRAM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        resp_err;

    always #5 clk = ~clk;

    cpu_sram_arbiter #(.MAX_OUTSTANDING(MAX), .ID_W(1)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata), .resp_err(resp_err)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: outstanding IDs in acceptance order (0 = inst, 1 = data),
    // the master whose presented request is still waiting, and the last winner.
    bit q[$];
    bit stalled;
    bit stalled_id;
    bit last_id;
    bit err_m;

    // Per-cycle expectations, held from the settle point to the clock edge.
    bit e_req, e_gid, e_accept, e_pop, e_stale;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic idle();
        inst_req    = 1'b0;
        inst_addr   = 32'd0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = 2'd0;
        data_addr   = 32'd0;
        data_wdata  = 32'd0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'd0;
    endtask

    task automatic settle_check();
        bit gv;
        bit head;
        #1;
        if (reset) begin
            q.delete();
            stalled  = 1'b0;
            last_id  = 1'b0;
            err_m    = 1'b0;
            e_req    = 1'b0;
            e_accept = 1'b0;
            e_pop    = 1'b0;
            e_stale  = 1'b0;
            chk1("rst_mem_req", mem_req, 1'b0);
            chk1("rst_inst_addr_ok", inst_addr_ok, 1'b0);
            chk1("rst_data_addr_ok", data_addr_ok, 1'b0);
            chk1("rst_inst_data_ok", inst_data_ok, 1'b0);
            chk1("rst_data_data_ok", data_data_ok, 1'b0);
            chk1("rst_resp_err", resp_err, 1'b0);
            return;
        end
        gv    = 1'b0;
        e_gid = 1'b0;
        if (q.size() < MAX) begin
            if (stalled) begin
                gv = 1'b1; e_gid = stalled_id;
            end else if (inst_req && data_req) begin
                gv = 1'b1; e_gid = RR_EN ? ~last_id : 1'b1;
            end else if (data_req) begin
                gv = 1'b1; e_gid = 1'b1;
            end else if (inst_req) begin
                gv = 1'b1; e_gid = 1'b0;
            end
        end
        e_req    = gv && (e_gid ? data_req : inst_req);
        e_accept = e_req && mem_addr_ok;
        e_pop    = mem_data_ok && (q.size() > 0);
        e_stale  = mem_data_ok && (q.size() == 0);
        head     = e_pop ? q[0] : 1'b0;

        chk1("mem_req", mem_req, e_req);
        chk1("inst_addr_ok", inst_addr_ok, e_accept && !e_gid);
        chk1("data_addr_ok", data_addr_ok, e_accept && e_gid);
        chk1("inst_data_ok", inst_data_ok, e_pop && !head);
        chk1("data_data_ok", data_data_ok, e_pop && head);
        chk32("inst_rdata", inst_rdata, mem_rdata);
        chk32("data_rdata", data_rdata, mem_rdata);
        chk1("resp_err", resp_err, err_m);
        if (e_req) begin
            chk32("mem_addr", mem_addr, e_gid ? data_addr : inst_addr);
            chk1("mem_wr", mem_wr, e_gid ? data_wr : 1'b0);
            chk32("mem_size", 32'(mem_size), e_gid ? 32'(data_size) : 32'd2);
            chk32("mem_wdata", mem_wdata, e_gid ? data_wdata : 32'd0);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (!reset) begin
            if (e_pop) void'(q.pop_front());
            if (e_stale) err_m = 1'b1;
            if (e_accept) begin
                q.push_back(e_gid);
                stalled = 1'b0;
                last_id = e_gid;
            end else if (e_req) begin
                stalled    = 1'b1;
                stalled_id = e_gid;
            end
        end
        @(negedge clk);
    endtask

    task automatic cyc();
        settle_check();
        advance();
    endtask

    task automatic accept_inst(input logic [31:0] a);
        idle(); inst_req = 1'b1; inst_addr = a; mem_addr_ok = 1'b1;
        cyc();
    endtask

    task automatic accept_data(input logic [31:0] a);
        idle(); data_req = 1'b1; data_addr = a; data_size = 2'd2; mem_addr_ok = 1'b1;
        cyc();
    endtask

    task automatic pop_one(input logic [31:0] d);
        idle(); mem_data_ok = 1'b1; mem_rdata = d;
        settle_check();
    endtask

    bit ip, dp;

    initial begin
        // Reset gating of outputs even with all inputs active.
        idle();
        reset = 1'b1;
        inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
        @(negedge clk);
        cyc();
        idle();
        reset = 1'b0;
        cyc();

        // Single instruction fetch, response two cycles after acceptance.
        accept_inst(32'hbfc00000);
        idle(); cyc();
        pop_one(32'h24080001);
        chk1("t1_inst_data_ok", inst_data_ok, 1'b1);
        chk32("t1_inst_rdata", inst_rdata, 32'h24080001);
        chk1("t1_data_data_ok", data_data_ok, 1'b0);
        advance();

        // Both masters request; data wins, inst follows.
        idle();
        inst_req = 1'b1; inst_addr = 32'hbfc00010;
        data_req = 1'b1; data_addr = 32'h80001000; data_size = 2'd2; mem_addr_ok = 1'b1;
        settle_check();
        chk32("t2_mem_addr", mem_addr, 32'h80001000);
        chk1("t2_data_addr_ok", data_addr_ok, 1'b1);
        chk1("t2_inst_addr_ok", inst_addr_ok, 1'b0);
        advance();
        data_req = 1'b0;
        settle_check();
        chk1("t2_inst_second", inst_addr_ok, 1'b1);
        chk32("t2_mem_addr2", mem_addr, 32'hbfc00010);
        advance();
        pop_one(32'h11111111);
        chk1("t2_resp0_data", data_data_ok, 1'b1);
        advance();
        pop_one(32'h22222222);
        chk1("t2_resp1_inst", inst_data_ok, 1'b1);
        advance();

        // After a data win, contention goes to inst only under round robin.
        accept_data(32'h80001004);
        idle();
        inst_req = 1'b1; inst_addr = 32'hbfc00014;
        data_req = 1'b1; data_addr = 32'h80001008; data_size = 2'd2; mem_addr_ok = 1'b1;
        settle_check();
        chk1("t2b_inst_first", inst_addr_ok, RR_EN);
        chk1("t2b_data_first", data_addr_ok, !RR_EN);
        advance();
        if (RR_EN) data_req = 1'b1; else inst_req = 1'b1;
        if (RR_EN) inst_req = 1'b0; else data_req = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin pop_one(32'(i)); advance(); end

        // Stalled inst request holds the port against a later data request.
        idle();
        inst_req = 1'b1; inst_addr = 32'hbfc00020;
        settle_check();
        chk32("t3_mem_addr_c1", mem_addr, 32'hbfc00020);
        advance();
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
        data_addr = 32'h80002000; data_wdata = 32'h000000a5;
        for (int i = 0; i < 2; i++) begin
            settle_check();
            chk32("t3_mem_addr_stall", mem_addr, 32'hbfc00020);
            chk1("t3_no_data_grant", data_addr_ok, 1'b0);
            advance();
        end
        mem_addr_ok = 1'b1;
        settle_check();
        chk1("t3_inst_accept", inst_addr_ok, 1'b1);
        advance();
        inst_req = 1'b0;
        settle_check();
        chk1("t3_data_accept", data_addr_ok, 1'b1);
        chk32("t3_data_addr", mem_addr, 32'h80002000);
        chk1("t3_data_wr", mem_wr, 1'b1);
        advance();
        pop_one(32'h0); chk1("t3_resp_inst", inst_data_ok, 1'b1); advance();
        pop_one(32'h0); chk1("t3_resp_data", data_data_ok, 1'b1); advance();

        // Fill the FIFO; full blocks the grant, even in the popping cycle.
        for (int i = 0; i < MAX; i++) accept_inst(32'hbfc00100 + 32'(4 * i));
        idle(); inst_req = 1'b1; inst_addr = 32'hbfc00200; mem_addr_ok = 1'b1;
        settle_check();
        chk1("t4_full_no_req", mem_req, 1'b0);
        advance();
        mem_data_ok = 1'b1; mem_rdata = 32'hcafe0000;
        settle_check();
        chk1("t4_full_pop_no_req", mem_req, 1'b0);
        chk1("t4_pop_ok", inst_data_ok, 1'b1);
        advance();
        mem_data_ok = 1'b0;
        settle_check();
        chk1("t4_fifth_granted", inst_addr_ok, 1'b1);
        advance();
        for (int i = 0; i < MAX; i++) begin pop_one(32'(i)); advance(); end

        // Response routing in acceptance order.
        accept_inst(32'hbfc00300);
        accept_data(32'h80003000);
        accept_inst(32'hbfc00304);
        pop_one(32'h1); chk1("t5_r0_inst", inst_data_ok, 1'b1); advance();
        pop_one(32'h2); chk1("t5_r1_data", data_data_ok, 1'b1); advance();
        pop_one(32'h3); chk1("t5_r2_inst", inst_data_ok, 1'b1); advance();

        // Stale response, sticky error, asynchronous reset clears it.
        pop_one(32'hdead0000);
        chk1("t6_stale_no_inst", inst_data_ok, 1'b0);
        chk1("t6_stale_no_data", data_data_ok, 1'b0);
        advance();
        idle(); settle_check(); chk1("t6_err_set", resp_err, 1'b1); advance();
        settle_check(); chk1("t6_err_hold", resp_err, 1'b1); advance();
        accept_inst(32'hbfc00400);
        accept_inst(32'hbfc00404);
        idle(); inst_req = 1'b1;
        reset = 1'b1;
        settle_check();
        chk1("t6_rst_err_clr", resp_err, 1'b0);
        advance();
        reset = 1'b0; idle();
        cyc();
        pop_one(32'h0);
        chk1("t6_stale_after_rst", inst_data_ok, 1'b0);
        advance();
        idle(); settle_check(); chk1("t6_err_again", resp_err, 1'b1); advance();

        // Randomised traffic: masters hold requests until accepted.
        reset = 1'b1; idle(); cyc();
        reset = 1'b0; cyc();
        ip = 1'b0; dp = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!ip && ($urandom_range(0, 2) == 0)) begin
                ip = 1'b1;
                inst_addr = $urandom & 32'hfffffffc;
            end
            if (!dp && ($urandom_range(0, 2) == 0)) begin
                dp = 1'b1;
                data_wr    = 1'($urandom);
                data_size  = 2'($urandom_range(0, 2));
                data_addr  = $urandom;
                data_wdata = $urandom;
            end
            inst_req    = ip;
            data_req    = dp;
            mem_addr_ok = ($urandom_range(0, 3) != 0);
            mem_data_ok = (q.size() > 0) ? 1'($urandom) : ($urandom_range(0, 199) == 0);
            mem_rdata   = $urandom;
            settle_check();
            if (e_accept) begin
                if (e_gid) dp = 1'b0; else ip = 1'b0;
            end
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cpu_sram_arbiter.md
Name: cpu_sram_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch master (pre-IF/IF stages) and the data master (EXE/MEM stages).
- Uses the same req/addr_ok/data_ok protocol on all three sides.
- Tracks accepted-but-unanswered requests in an in-order ID FIFO, so each data_ok is routed to the master that issued the request.
- Sits between the CPU pipeline and the memory/AXI bridge.

Parameters:
MAX_OUTSTANDING, 4, depth of the response-routing FIFO; power of 2, at least 2
ID_W, 1, master ID width (0 = inst, 1 = data)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
inst_req  in  1  inst master request
inst_addr  in  32  inst request address (read only)
inst_addr_ok  out  1  inst request accepted this cycle
inst_data_ok  out  1  inst read data valid this cycle
inst_rdata  out  32  read data
data_req  in  1  data master request
data_wr  in  1  1 = write
data_size  in  2  0 = byte, 1 = half, 2 = word
data_addr  in  32  data request address
data_wdata  in  32  write data
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  data response (read data or write ack) this cycle
data_rdata  out  32  read data
mem_req  out  1  request to memory
mem_wr  out  1  write flag to memory
mem_size  out  2  size to memory
mem_addr  out  32  address to memory
mem_wdata  out  32  write data to memory
mem_addr_ok  in  1  memory accepted the request
mem_data_ok  in  1  memory response valid
mem_rdata  in  32  memory read data
resp_err  out  1  sticky flag: mem_data_ok arrived while the FIFO was empty

Behaviour:
- Reset (asynchronous): FIFO pointers and count = 0, lock = 0, lock_id = 0, rr_last = 0, resp_err = 0.
  - While reset is high, mem_req, inst_addr_ok, data_addr_ok, inst_data_ok and data_data_ok all read 0.
- Grant (combinational):
  - No grant when the FIFO is full (count == MAX_OUTSTANDING).
  - If lock = 1, grant lock_id.
  - Otherwise, with both requests high, data wins (fixed priority); with one request high, that master wins.
- Memory drive:
  - mem_req = granted master's req.
  - mem_wr/mem_size/mem_addr/mem_wdata are muxed from the granted master.
  - An inst grant drives mem_wr = 0, mem_size = 2, mem_wdata = 0.
- Acceptance: master addr_ok = mem_addr_ok && mem_req && grant == that master. This is a 0-cycle pass-through.
- Lock:
  - Set when mem_req = 1 and mem_addr_ok = 0; lock_id captures the granted ID.
  - Cleared on the cycle the handshake completes.
  - While locked, the other master cannot preempt, even if it has priority.
- FIFO push: on every accepted handshake, write the granted ID at the write pointer; the pointer wraps modulo MAX_OUTSTANDING.
- FIFO pop:
  - mem_data_ok with count > 0 pops the head ID.
  - Head ID 0 pulses inst_data_ok; head ID 1 pulses data_data_ok (both are 0-cycle combinational).
  - mem_rdata is broadcast to inst_rdata and data_rdata.
- Simultaneous push and pop: both take effect and count is unchanged.
  - Full plus a pop in the same cycle still blocks the grant; the freed slot becomes usable the next cycle.
- Pop on an empty FIFO: the response is dropped, no data_ok is raised, and resp_err sets and stays set until reset.
- Response ordering is strictly in acceptance order; there is no reordering.

Optional Feature:
- Macro: CPU_SRAM_ARB_RR_EN.
- Defined: when both requests are high and lock = 0, grant the master that was not granted last (rr_last).
  - rr_last updates on each accepted handshake.
  - This prevents instruction starvation during load/store bursts.
- Undefined: fixed data-over-inst priority; the rr_last register is not built.

Test Plan:
- inst_req = 1, inst_addr = 0xbfc00000, mem_addr_ok = 1 the same cycle, mem_data_ok with rdata 0x24080001 two cycles later:
  - inst_addr_ok = 1 in the same cycle.
  - inst_data_ok = 1 and inst_rdata = 0x24080001 two cycles later.
  - data_data_ok stays 0.
- inst_req and data_req both high with data_addr = 0x80001000:
  - mem_addr = 0x80001000 and data_addr_ok fires first.
  - The inst request is granted the next cycle.
  - With CPU_SRAM_ARB_RR_EN defined and rr_last = data, inst is granted first instead.
- Inst request stalled 3 cycles with mem_addr_ok = 0 while data_req rises in cycle 2:
  - mem_addr stays on the inst address until acceptance.
  - Data is granted afterwards.
- Issue 4 accepted requests with no responses:
  - A 5th request sees mem_req = 0.
  - After one mem_data_ok, the 5th request is granted the following cycle.
- Accept order inst, data, inst, then 3 mem_data_ok pulses:
  - Responses arrive as inst_data_ok, data_data_ok, inst_data_ok in that order.
- mem_data_ok with an empty FIFO:
  - resp_err rises and holds.
  - Asserting reset mid-stream with 2 requests outstanding clears resp_err and count immediately.
  - Subsequent stale mem_data_ok pulses set resp_err again.
